// File: rtl/banner_pkg.sv
// Shared definitions for the banner sequencer.
// Contents: character code constants and the controller state encoding.
package banner_pkg;

  // Character codes: 5'h00..5'h0F are the hex digits 0..F, 5'h1F is a blank digit.
  localparam logic [4:0] BLANK = 5'h1F;
  localparam logic [4:0] CH_0  = 5'h00;
  localparam logic [4:0] CH_F  = 5'h0F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Scroll-step timebase.
// Counts 0..TICK-1 while run is high and pulses tick for one cycle on the
// last count. Any cycle with run low returns the counter to 0, so a restart
// always yields a full TICK-cycle interval before the first pulse.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   run  - count enable; low clears the counter
//   tick - one-cycle pulse at count TICK-1
module tick_gen
  import banner_pkg::*;
#(
  parameter int TICK = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/banner_sequencer.sv
// Scrolling banner controller.
// A message of up to LEN character codes is written into an internal buffer,
// then shown as a six-character window that scrolls by one position every
// TICK cycles while en is high. dig0..dig5 feed LED_mux in0..in5 directly.
//
// Write handshake: a character is accepted on a rising edge where wr_valid
// and wr_ready are both high and clear is low. wr_ready is high only in
// IDLE/LOAD; writes offered in RUN/HOLD are ignored until clear.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   en                - scrolling enabled (low pauses in HOLD)
//   dir               - 1 scrolls left (pos+1), 0 scrolls right (pos-1)
//   clear             - synchronous abort to IDLE, beats a same-cycle write
//   wr_valid/wr_data/wr_last/wr_ready - character write port
//   dig0..dig5        - registered character codes for the six digits
//   busy              - high in RUN or HOLD
module banner_sequencer
  import banner_pkg::*;
#(
  parameter int TICK = 25_000_000,
  parameter int LEN  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       clear,
  input  logic       wr_valid,
  input  logic [4:0] wr_data,
  input  logic       wr_last,
  output logic       wr_ready,
  output logic [4:0] dig0,
  output logic [4:0] dig1,
  output logic [4:0] dig2,
  output logic [4:0] dig3,
  output logic [4:0] dig4,
  output logic [4:0] dig5,
  output logic       busy
);

  localparam int PW = $clog2(LEN);  // buffer index width
  localparam int LW = PW + 1;       // message length width (holds LEN)
  localparam int SW = LW + 2;       // headroom for pos + 5

  state_t        state, state_next;
  logic [PW-1:0] wr_ptr, wr_ptr_next;
  logic [PW-1:0] pos, pos_next;
  logic [LW-1:0] msg_len, msg_len_next;
  logic [4:0]    msg_buf [LEN];
  logic [4:0]    dig_q [6];
  logic [4:0]    dig_next [6];
  logic          accept;
  logic          run;
  logic          tick;
  logic [PW-1:0] pos_fwd, pos_back;

  // (p + k) mod len for p < len, k <= 5. Repeated subtraction covers the
  // worst case len == 1, which needs five wraps.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p,
                                             input logic [2:0]    k,
                                             input logic [LW-1:0] len);
    logic [SW-1:0] s;
    s = SW'(p) + SW'(k);
    for (int i = 0; i < 6; i++) begin
      if (s >= SW'(len)) s = s - SW'(len);
    end
    return PW'(s);
  endfunction

  assign wr_ready = (state == IDLE) || (state == LOAD);
  assign busy     = (state == RUN) || (state == HOLD);
  assign accept   = wr_valid && wr_ready && !clear;

  // The counter only runs while actually scrolling; HOLD and the cycle that
  // leaves RUN both clear it, so resuming gives a full interval.
  assign run = (state == RUN) && en && !clear;

  tick_gen #(.TICK(TICK)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  assign pos_fwd  = ((LW'(pos) + LW'(1)) == msg_len) ? '0 : pos + PW'(1);
  assign pos_back = (pos == '0) ? PW'(msg_len - LW'(1)) : pos - PW'(1);

  always_comb begin
    state_next   = state;
    wr_ptr_next  = wr_ptr;
    pos_next     = pos;
    msg_len_next = msg_len;
    if (clear) begin
      state_next   = IDLE;
      wr_ptr_next  = '0;
      pos_next     = '0;
      msg_len_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wr_ptr_next = PW'(1);
            pos_next    = '0;
            if (wr_last) begin
              state_next   = RUN;
              msg_len_next = LW'(1);
            end else begin
              state_next = LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wr_ptr_next = wr_ptr + PW'(1);
            if (wr_last || wr_ptr == PW'(LEN - 1)) begin
              state_next   = RUN;
              msg_len_next = LW'(wr_ptr) + LW'(1);
              pos_next     = '0;
            end
          end
        end
        RUN: begin
          if (!en) begin
            state_next = HOLD;
          end else if (tick) begin
            pos_next = dir ? pos_fwd : pos_back;
          end
        end
        HOLD: begin
          if (en) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Digits follow the current pos, so they lag a pos change by one cycle.
  // The cycle that enters RUN still shows BLANK because msg_len is only
  // being written on that edge.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      dig_next[k] = BLANK;
      if (busy && !clear) begin
        dig_next[k] = msg_buf[wrap_idx(pos, 3'(k), msg_len)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      pos     <= '0;
      msg_len <= '0;
      for (int k = 0; k < 6; k++) dig_q[k] <= BLANK;
    end else begin
      state   <= state_next;
      wr_ptr  <= wr_ptr_next;
      pos     <= pos_next;
      msg_len <= msg_len_next;
      for (int k = 0; k < 6; k++) dig_q[k] <= dig_next[k];
    end
  end

  // Buffer contents survive reset; a message is only readable once rewritten.
  always_ff @(posedge clk) begin
    if (accept) msg_buf[wr_ptr] <= wr_data;
  end

  assign dig0 = dig_q[0];
  assign dig1 = dig_q[1];
  assign dig2 = dig_q[2];
  assign dig3 = dig_q[3];
  assign dig4 = dig_q[4];
  assign dig5 = dig_q[5];

endmodule

// File: tb/tb_banner_sequencer.sv
// Bench for banner_sequencer with TICK=4, LEN=16. The reference model keeps
// the message as a plain array plus a scroll position and derives the digit
// window with modular arithmetic.
module tb_banner_sequencer;
  import banner_pkg::*;

  localparam int TICK = 4;
  localparam int LEN  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       clear = 1'b0;
  logic       wr_valid = 1'b0;
  logic [4:0] wr_data = '0;
  logic       wr_last = 1'b0;
  logic       wr_ready;
  logic [4:0] dig0, dig1, dig2, dig3, dig4, dig5;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [4:0]  mdl [LEN];
  int          mlen = 0;
  int          mpos = 0;
  logic [29:0] exp_q [$];

  banner_sequencer #(.TICK(TICK), .LEN(LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .clear    (clear),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .wr_ready (wr_ready),
    .dig0     (dig0),
    .dig1     (dig1),
    .dig2     (dig2),
    .dig3     (dig3),
    .dig4     (dig4),
    .dig5     (dig5),
    .busy     (busy)
  );

  // clock
  initial forever #5 clk = ~clk;

  // watchdog
  initial begin
    #500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  function automatic logic [29:0] model_digs();
    logic [29:0] e;
    e = '0;
    for (int k = 0; k < 6; k++) e[k*5 +: 5] = mdl[(mpos + k) % mlen];
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_digs(input string tag);
    logic [29:0] e;
    exp_q.push_back(model_digs());
    e = exp_q.pop_front();
    check(tag, {2'b00, dig5, dig4, dig3, dig2, dig1, dig0}, {2'b00, e});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_digs"}, {2'b00, dig5, dig4, dig3, dig2, dig1, dig0}, {2'b00, {6{BLANK}}});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_rdy"}, {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic write_char(input logic [4:0] d, input logic last);
    check("wr_ready_load", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    cyc(1);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Writes mdl[0..n-1]; optionally offers one extra write once the message is in.
  task automatic load_msg(input int n, input logic use_last, input logic extra);
    for (int i = 0; i < n; i++) write_char(mdl[i], use_last && (i == n - 1));
    mlen = n;
    mpos = 0;
    if (extra) begin
      check("extra_wr_ready", {31'd0, wr_ready}, 32'd0);
      wr_valid = 1'b1;
      wr_data  = 5'h1E;
    end
    cyc(1);
    wr_valid = 1'b0;
    check_digs("load_digs");
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_rdy", {31'd0, wr_ready}, 32'd0);
  endtask

  task automatic step(input logic d);
    dir = d;
    mpos = d ? (mpos + 1) % mlen : (mpos + mlen - 1) % mlen;
    cyc(TICK);
    check_digs(d ? "step_left" : "step_right");
  endtask

  task automatic do_clear(input logic with_write);
    clear = 1'b1;
    if (with_write) begin
      wr_valid = 1'b1;
      wr_data  = 5'h15;
    end
    cyc(1);
    clear    = 1'b0;
    wr_valid = 1'b0;
    check_idle("clear");
  endtask

  initial begin
    int n;
    logic ul;

    // reset state while rst is held
    cyc(2);
    check_idle("reset");
    rst = 1'b0;
    en  = 1'b1;

    // message 1..8 with wr_last on 8, scroll left
    for (int i = 0; i < 8; i++) mdl[i] = 5'(i + 1);
    load_msg(8, 1'b1, 1'b0);
    step(1'b1);
    step(1'b1);
    do_clear(1'b0);
    do_clear(1'b1);  // clear beats a same-cycle write in IDLE

    // same message, first step right wraps pos 0 -> 7
    load_msg(8, 1'b1, 1'b0);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    do_clear(1'b0);

    // full buffer 0..F without wr_last; a 17th write is refused
    for (int i = 0; i < LEN; i++) mdl[i] = 5'(i);
    load_msg(LEN, 1'b0, 1'b1);
    for (int i = 0; i < LEN; i++) step(1'b1);
    do_clear(1'b0);

    // short message A,B,C repeats across the window
    mdl[0] = 5'h0A;
    mdl[1] = 5'h0B;
    mdl[2] = 5'h0C;
    load_msg(3, 1'b1, 1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b0);

    // pause for 20 cycles, then resume: next step lands TICK cycles after RUN
    en = 1'b0;
    cyc(20);
    check_digs("hold_frozen");
    check("hold_busy", {31'd0, busy}, 32'd1);
    check("hold_rdy", {31'd0, wr_ready}, 32'd0);
    en  = 1'b1;
    dir = 1'b1;
    cyc(TICK + 1);
    check_digs("resume_early");
    mpos = (mpos + 1) % mlen;
    cyc(1);
    check_digs("resume_step");
    step(1'b1);

    // clear mid-RUN, then a fresh message
    do_clear(1'b0);
    for (int i = 0; i < 5; i++) mdl[i] = 5'(i + 3);
    load_msg(5, 1'b1, 1'b0);
    step(1'b0);

    // clear mid-LOAD
    do_clear(1'b0);
    write_char(5'h07, 1'b0);
    write_char(5'h08, 1'b0);
    do_clear(1'b0);
    for (int i = 0; i < 7; i++) mdl[i] = 5'(9 + i);
    load_msg(7, 1'b1, 1'b0);
    step(1'b1);

    // reset mid-RUN
    rst = 1'b1;
    #2;
    check_idle("rst_run");
    cyc(1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) mdl[i] = 5'(15 - i);
    load_msg(6, 1'b1, 1'b0);
    step(1'b0);

    // reset mid-LOAD
    do_clear(1'b0);
    write_char(5'h01, 1'b0);
    write_char(5'h02, 1'b0);
    write_char(5'h03, 1'b0);
    rst = 1'b1;
    #2;
    check_idle("rst_load");
    cyc(1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = 5'(i + 12);
    load_msg(4, 1'b1, 1'b0);
    step(1'b1);
    do_clear(1'b0);

    // randomized messages and scroll directions
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, LEN);
      for (int i = 0; i < n; i++) mdl[i] = 5'($urandom_range(0, 31));
      ul = (n < LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      load_msg(n, ul, 1'b0);
      repeat ($urandom_range(3, 8)) step(1'($urandom_range(0, 1)));
      do_clear(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/banner_sequencer.md
BANNER_SEQUENCER -- requirements
Module: banner_sequencer

Interface
REQ-001 SHALL have parameter TICK, default 25_000_000, meaning clock cycles per scroll step.
REQ-002 SHALL have parameter LEN, default 16, meaning message buffer depth in characters (power of two, at least 6).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  meaning scrolling is enabled while high.
REQ-006 SHALL have port dir  input  1  meaning 1 scrolls left (pos+1) and 0 scrolls right (pos-1).
REQ-007 SHALL have port clear  input  1  meaning a synchronous abort to IDLE.
REQ-008 SHALL have port wr_valid  input  1  meaning a character write request.
REQ-009 SHALL have port wr_data  input  5  meaning the character code.
REQ-010 SHALL have port wr_last  input  1  meaning the final character of the message.
REQ-011 SHALL have port wr_ready  output  1  meaning the buffer accepts a write.
REQ-012 SHALL have ports dig0..dig5  output  5 each  meaning the character codes for the six display digits, in0..in5 order.
REQ-013 SHALL have port busy  output  1  meaning state is RUN or HOLD.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RUN, HOLD.
REQ-015 SHALL treat a write as accepted on a cycle where wr_valid and wr_ready are both high; wr_ready SHALL be 1 in IDLE/LOAD and 0 in RUN/HOLD.
REQ-016 SHALL, in IDLE, on an accepted write, store wr_data at buf[0], set wr_ptr=1, and go to LOAD; if wr_last is also high, it SHALL instead go directly to RUN with msg_len=1.
REQ-017 SHALL, in LOAD, store each accepted write at buf[wr_ptr] and increment wr_ptr.
REQ-018 SHALL end LOAD on an accepted write with wr_last=1, or on an accepted write at wr_ptr==LEN-1 (buffer full), setting msg_len=wr_ptr+1 and pos=0, and go to RUN.
REQ-019 SHALL keep an internal tick counter that counts 0..TICK-1 and pulses tick for one cycle at TICK-1; the counter SHALL count only in RUN and be cleared in every other state.
REQ-020 SHALL, in RUN on a tick with en=1, update pos to (pos+1) mod msg_len when dir=1, or (pos-1) mod msg_len when dir=0; at pos==0 with dir=0, pos SHALL become msg_len-1.
REQ-021 SHALL move from RUN to HOLD when en=0, holding pos and dig outputs; it SHALL return from HOLD to RUN when en=1, with the tick counter restarting from 0.
REQ-022 SHALL sample dir at each tick; a change of dir SHALL take effect at the next tick.
REQ-023 SHALL, in RUN/HOLD, register digK = buf[(pos+K) mod msg_len] for K=0..5, with one cycle of latency after a pos change; when msg_len<6, indices SHALL wrap and characters repeat.
REQ-024 SHALL drive every dig to BLANK in IDLE and LOAD.
REQ-025 SHALL, when clear=1 in any state, go to IDLE next cycle with wr_ptr=0, pos=0, msg_len=0, and the tick counter at 0; clear SHALL take priority over a write in the same cycle, which is not accepted.
REQ-026 SHALL ignore wr_valid in RUN/HOLD; a new message requires clear first.

Reset
REQ-027 SHALL, while rst=1, immediately force state=IDLE, wr_ptr=0, pos=0, msg_len=0, tick counter 0, dig0..dig5=BLANK, busy=0, and wr_ready=1.
REQ-028 SHALL not reset the buffer contents, which are unreadable until rewritten; reset in mid-LOAD or mid-RUN SHALL discard the message.

Structure
REQ-029 SHALL place character code constants (BLANK=5'h1F, digits 0-F = 5'h00-5'h0F) and the FSM state encoding in a shared package, banner_pkg.
REQ-030 SHALL implement the tick counter as sub-module tick_gen (parameter TICK; ports clk, rst, run, tick).
REQ-031 SHALL have outputs dig0..dig5 connect directly to LED_mux in0..in5.

Verification (TICK=4, LEN=16)
REQ-032 SHALL cover: write 1,2,3,4,5,6,7,8 with wr_last on 8 -> busy=1, dig0..dig5=1..6, and after 4 clk with en=1,dir=1, digits=2..7.
REQ-033 SHALL cover: the same message with dir=0 -> the first tick gives dig0..dig5=8,1,2,3,4,5.
REQ-034 SHALL cover: write 16 characters 0..F without wr_last -> RUN after the 16th; a 17th wr_valid sees wr_ready=0; pos wraps 15->0 with dir=1.
REQ-035 SHALL cover: a 3-character message A,B,C -> dig0..dig5=A,B,C,A,B,C.
REQ-036 SHALL cover: en=0 for 20 cycles mid-RUN -> HOLD, digits frozen; en=1 -> the next step occurs exactly 4 cycles later.
REQ-037 SHALL cover: rst or clear asserted mid-LOAD and mid-RUN -> all dig=1F, wr_ready=1, busy=0, and a new message loads correctly.
